// File: rtl/restoring_divider_pkg.sv
// ============================================================================
//  Module      : restoring_divider_pkg
//  Description : Shared definitions for the sequential restoring divider:
//                FSM state encoding, default operand width and the
//                iteration-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package restoring_divider_pkg;

    // Default operand width for dividend, divisor, quotient and remainder.
    localparam int DIV_WIDTH = 4;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Bits needed for a counter that must hold the value WIDTH.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : restoring_divider_pkg

`default_nettype wire

// File: rtl/restoring_divider_ripple_subtractor.sv
// ============================================================================
//  Module      : ripple_subtractor
//  Description : N-bit ripple-borrow subtractor, diff = a - b - borrow_in.
//                Built from gate-level full-subtractor cells chained through
//                their borrow, the mirror image of the full-adder carry chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         borrow_in_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_out_o
);

    // borrow_chain[k] is the borrow entering cell k; the final entry leaves the MSB.
    logic [N:0] borrow_chain;

    assign borrow_chain[0] = borrow_in_i;

    // One full-subtractor cell per bit position.
    generate
        for (genvar k = 0; k < N; k++) begin : g_cell
            logic w_axb;
            assign w_axb              = a_i[k] ^ b_i[k];
            assign diff_o[k]          = w_axb ^ borrow_chain[k];
            // Borrow when b exceeds a, or when they are equal and a borrow arrives.
            assign borrow_chain[k+1]  = (~a_i[k] & b_i[k]) | (~w_axb & borrow_chain[k]);
        end
    endgenerate

    assign borrow_out_o = borrow_chain[N];

endmodule : ripple_subtractor

`default_nettype wire

// File: rtl/restoring_divider.sv
// ============================================================================
//  Module      : restoring_divider
//  Description : Sequential unsigned WIDTH-bit restoring divider. One quotient
//                bit per clock, valid/ready handshakes on operand and result
//                sides, divide-by-zero flagged without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int                CNT_W      = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  ITER_LAST  = CNT_W'(WIDTH - 1);

    // Control state and iteration count.
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Working registers: partial remainder R (one guard bit), shifting Q, divisor latch.
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    // Result registers presented to the consumer.
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // One restoring step: shift {R,Q} left, then trial-subtract the divisor from R.
    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH-1:0] w_shift_quo;
    logic [WIDTH:0]   w_trial_diff;
    logic             w_trial_borrow;
    logic [WIDTH:0]   w_iter_rem;
    logic [WIDTH-1:0] w_iter_quo;

    assign w_shift     = {rem_q, quo_q} << 1;
    assign w_shift_rem = w_shift[2*WIDTH:WIDTH];
    assign w_shift_quo = w_shift[WIDTH-1:0];

    ripple_subtractor #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a_i          (w_shift_rem),
        .b_i          ({1'b0, divisor_q}),
        .borrow_in_i  (1'b0),
        .diff_o       (w_trial_diff),
        .borrow_out_o (w_trial_borrow)
    );

    // No borrow means the divisor fits: keep the difference and set the quotient bit.
    assign w_iter_rem = w_trial_borrow ? w_shift_rem : w_trial_diff;
    assign w_iter_quo = {w_shift_quo[WIDTH-1:1], ~w_trial_borrow};

    // Next-state and datapath decode; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    divisor_d = divisor_i;
                    quo_d     = dividend_i;
                    rem_d     = '0;
                    count_d   = '0;
                    if (divisor_i == '0) begin
                        // Zero divisor resolves immediately with a saturated quotient.
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                rem_d   = w_iter_rem;
                quo_d   = w_iter_quo;
                count_d = count_q + 1'b1;
                if (count_q == ITER_LAST) begin
                    quotient_d  = w_iter_quo;
                    remainder_d = w_iter_rem[WIDTH-1:0];
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == ST_IDLE);
    assign out_valid_o   = (state_q == ST_DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule : restoring_divider

`default_nettype wire
